// File: rtl/bram_matrix_scanner_pkg.sv
// Shared definitions for the BRAM matrix address engines: default geometry,
// derived sizes and scanner FSM state encoding.
package bram_matrix_scanner_pkg;

    localparam int unsigned DEF_I_SIZE           = 3;
    localparam int unsigned DEF_BRAM_NUMBER_SIZE = 5;
    localparam int unsigned DEF_J_SIZE           = 8;
    localparam int unsigned DEF_BRAM_COUNT       = 2 ** DEF_BRAM_NUMBER_SIZE;
    localparam int unsigned DEF_ADDR_SIZE        = DEF_J_SIZE - (DEF_BRAM_NUMBER_SIZE - DEF_I_SIZE);
    localparam int unsigned STALL_W              = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/bram_addr_map.sv
// Combinational (i, j) -> (bank, in-bank address) mapping.
// Bank number is j's low bits stacked above i; the remaining j bits form the address.
module bram_addr_map
    import bram_matrix_scanner_pkg::*;
#(
    parameter int unsigned  I_SIZE           = DEF_I_SIZE,
    parameter int unsigned  BRAM_NUMBER_SIZE = DEF_BRAM_NUMBER_SIZE,
    parameter int unsigned  J_SIZE           = DEF_J_SIZE,
    localparam int unsigned J_LOW            = BRAM_NUMBER_SIZE - I_SIZE,
    localparam int unsigned ADDR_SIZE        = J_SIZE - J_LOW
) (
    input  logic [I_SIZE-1:0]           i_i,
    input  logic [J_SIZE-1:0]           j_i,
    output logic [BRAM_NUMBER_SIZE-1:0] bank_o,
    output logic [ADDR_SIZE-1:0]        addr_o
);

    generate
        if (J_LOW > 0) begin : g_split
            assign bank_o = {j_i[J_LOW-1:0], i_i};
        end else begin : g_ionly
            assign bank_o = i_i;
        end
    endgenerate

    assign addr_o = j_i[J_SIZE-1:J_LOW];

endmodule

// File: rtl/bram_matrix_scanner.sv
// Walks an (i, j) coefficient matrix in row- or column-major order and issues
// one bank/address request per element over a valid/ready handshake.
// Optional SCANNER_STALL_COUNT_EN adds a saturating backpressure cycle counter.
module bram_matrix_scanner
    import bram_matrix_scanner_pkg::*;
#(
    parameter int unsigned  I_SIZE           = DEF_I_SIZE,
    parameter int unsigned  BRAM_NUMBER_SIZE = DEF_BRAM_NUMBER_SIZE,
    parameter int unsigned  J_SIZE           = DEF_J_SIZE,
    localparam int unsigned ADDR_SIZE        = J_SIZE - (BRAM_NUMBER_SIZE - I_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        col_major,
    input  logic [I_SIZE-1:0]           i_last,
    input  logic [J_SIZE-1:0]           j_last,
    output logic                        busy,
    output logic                        done,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [BRAM_NUMBER_SIZE-1:0] req_bank,
    output logic [ADDR_SIZE-1:0]        req_addr,
    output logic [I_SIZE-1:0]           req_i,
    output logic [J_SIZE-1:0]           req_j
`ifdef SCANNER_STALL_COUNT_EN
    ,
    output logic [STALL_W-1:0]          stall_cycles
`endif
);

    scan_state_e                 state_q, state_d;
    logic [I_SIZE-1:0]           i_q, i_d, i_last_q, i_last_d;
    logic [J_SIZE-1:0]           j_q, j_d, j_last_q, j_last_d;
    logic                        col_major_q, col_major_d;
    logic                        valid_q, busy_q, done_q;
    logic [BRAM_NUMBER_SIZE-1:0] bank_q, bank_d;
    logic [ADDR_SIZE-1:0]        addr_q, addr_d;
    logic                        load, fire, at_last;

    // Mapping sits on the next-index path so bank/addr come straight from flops.
    bram_addr_map #(
        .I_SIZE           (I_SIZE),
        .BRAM_NUMBER_SIZE (BRAM_NUMBER_SIZE),
        .J_SIZE           (J_SIZE)
    ) u_map (
        .i_i    (i_d),
        .j_i    (j_d),
        .bank_o (bank_d),
        .addr_o (addr_d)
    );

    // Next-state and index advance; last element holds indices and exits RUN.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        i_last_d    = i_last_q;
        j_last_d    = j_last_q;
        col_major_d = col_major_q;
        load        = 1'b0;
        fire        = valid_q && req_ready;
        at_last     = (i_q == i_last_q) && (j_q == j_last_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    state_d     = RUN;
                    i_d         = '0;
                    j_d         = '0;
                    i_last_d    = i_last;
                    j_last_d    = j_last;
                    col_major_d = col_major;
                end
            end
            RUN: begin
                if (fire) begin
                    if (at_last) begin
                        state_d = DONE;
                    end else if (!col_major_q) begin
                        if (j_q == j_last_q) begin
                            j_d = '0;
                            i_d = i_q + I_SIZE'(1);
                        end else begin
                            j_d = j_q + J_SIZE'(1);
                        end
                    end else begin
                        if (i_q == i_last_q) begin
                            i_d = '0;
                            j_d = j_q + J_SIZE'(1);
                        end else begin
                            i_d = i_q + I_SIZE'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, indices and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            i_last_q    <= '0;
            j_last_q    <= '0;
            col_major_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bank_q      <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            i_last_q    <= i_last_d;
            j_last_q    <= j_last_d;
            col_major_q <= col_major_d;
            valid_q     <= (state_d == RUN);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            bank_q      <= bank_d;
            addr_q      <= addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign req_valid = valid_q;
    assign req_bank  = bank_q;
    assign req_addr  = addr_q;
    assign req_i     = i_q;
    assign req_j     = j_q;

`ifdef SCANNER_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Count stalled request cycles, cleared on scan start, saturating.
    always_comb begin
        stall_d = stall_q;
        if (load) begin
            stall_d = '0;
        end else if (valid_q && !req_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_bram_matrix_scanner.sv
// Scoreboard bench for bram_matrix_scanner: expected requests are queued at
// start and popped on each observed transfer.
module tb_bram_matrix_scanner;
    import bram_matrix_scanner_pkg::*;

    localparam int unsigned IS = DEF_I_SIZE;
    localparam int unsigned BS = DEF_BRAM_NUMBER_SIZE;
    localparam int unsigned JS = DEF_J_SIZE;
    localparam int unsigned JL = BS - IS;
    localparam int unsigned AS = JS - JL;

    typedef struct packed {
        logic [IS-1:0] i;
        logic [JS-1:0] j;
        logic [BS-1:0] bank;
        logic [AS-1:0] addr;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          col_major = 1'b0;
    logic          req_ready = 1'b0;
    logic [IS-1:0] i_last = '0;
    logic [JS-1:0] j_last = '0;
    logic          busy, done, req_valid;
    logic [BS-1:0] req_bank;
    logic [AS-1:0] req_addr;
    logic [IS-1:0] req_i;
    logic [JS-1:0] req_j;
`ifdef SCANNER_STALL_COUNT_EN
    logic [15:0]   stall_cycles;
    logic [15:0]   stall_at_done = '0;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    int   n_done  = 0;
    bit   rand_ready = 1'b0;
    bit   prev_stall = 1'b0;
    req_t prev_fields;
    req_t exp_q[$];

    bram_matrix_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .col_major (col_major),
        .i_last    (i_last),
        .j_last    (j_last),
        .busy      (busy),
        .done      (done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bank  (req_bank),
        .req_addr  (req_addr),
        .req_i     (req_i),
        .req_j     (req_j)
`ifdef SCANNER_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input int i, input int j);
        req_t r;
        r.i    = IS'(i);
        r.j    = JS'(j);
        r.bank = BS'((j % (1 << JL)) * (1 << IS) + i);
        r.addr = AS'(j >> JL);
        return r;
    endfunction

    task automatic push_scan(input bit cm, input int il, input int jl);
        if (!cm) begin
            for (int i = 0; i <= il; i++)
                for (int j = 0; j <= jl; j++) exp_q.push_back(mk(i, j));
        end else begin
            for (int j = 0; j <= jl; j++)
                for (int i = 0; i <= il; i++) exp_q.push_back(mk(i, j));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first RUN cycle.
    task automatic launch(input bit cm, input int il, input int jl);
        push_scan(cm, il, jl);
        col_major = cm;
        i_last    = IS'(il);
        j_last    = JS'(jl);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int done_before);
        int k = 0;
        while (n_done == done_before && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(n_done != done_before), 64'd1);
    endtask

    task automatic run_scan(input string tag, input bit cm, input int il, input int jl);
        int d0 = n_done;
        int x0 = n_xfer;
        launch(cm, il, jl);
        wait_done({tag, "_done_seen"}, (il + 1) * (jl + 1) * 4 + 20, d0);
        repeat (3) step();
        chk({tag, "_xfers"}, 64'(n_xfer - x0), 64'((il + 1) * (jl + 1)));
        chk({tag, "_done_cnt"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle"}, 64'({busy, req_valid}), 64'd0);
    endtask

    // Random backpressure source.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            req_ready = 1'($urandom_range(0, 1));
        end
    end

    // Transfer monitor: scoreboard pop, stall-hold check, done counting.
    always @(negedge clk) begin
        req_t cur;
        cur = '{i: req_i, j: req_j, bank: req_bank, addr: req_addr};
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(req_valid), 64'd1);
                chk("hold_fields", 64'(cur), 64'(prev_fields));
            end
            prev_stall  = req_valid && !req_ready;
            prev_fields = cur;
            if (req_valid && req_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 64'(cur), 64'hDEAD);
                end else begin
                    chk("req", 64'(cur), 64'(exp_q.pop_front()));
                end
            end
            if (done) begin
                n_done++;
`ifdef SCANNER_STALL_COUNT_EN
                stall_at_done = stall_cycles;
`endif
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int d0, x0, done_cyc;
        logic [7:0] busy_hist;

        // Reset values
        repeat (2) step();
        @(negedge clk);
        chk("reset_outs", 64'({busy, done, req_valid, req_bank, req_addr, req_i, req_j}), 64'd0);
`ifdef SCANNER_STALL_COUNT_EN
        chk("reset_stall", 64'(stall_cycles), 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Row-major 2x2 with cycle-exact timing
        req_ready = 1'b1;
        d0 = n_done;
        x0 = n_xfer;
        busy_hist = '0;
        done_cyc = 0;
        launch(1'b0, 1, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            busy_hist[c] = busy;
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 1) chk("t1_valid_c1", 64'(req_valid), 64'd1);
            if (c == 5) chk("t1_valid_drop", 64'(req_valid), 64'd0);
            step();
        end
        chk("t1_done_cycle", 64'(done_cyc), 64'd5);
        chk("t1_busy_window", 64'(busy_hist), 64'h3E);
        chk("t1_xfers", 64'(n_xfer - x0), 64'd4);
        chk("t1_done_cnt", 64'(n_done - d0), 64'd1);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // Column-major 2x2, mapping edge, full max-index scan
        run_scan("colmaj", 1'b1, 1, 1);
        run_scan("map_edge", 1'b0, 7, 5);
        run_scan("full", 1'b0, 7, 255);

        // Random backpressure, column-major
        rand_ready = 1'b1;
        run_scan("rand_cm", 1'b1, 5, 6);
        rand_ready = 1'b0;
        step();
        req_ready = 1'b1;
        step();

        // Three-cycle stall on the second request
        d0 = n_done;
        x0 = n_xfer;
        launch(1'b0, 1, 1);
        step();
        req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req_ready = 1'b1;
            @(negedge clk);
            chk("bp_valid", 64'(req_valid), 64'd1);
            chk("bp_fields", 64'({req_i, req_j, req_bank, req_addr}), 64'(mk(0, 1)));
            step();
        end
        wait_done("bp_done_seen", 40, d0);
        repeat (2) step();
        chk("bp_xfers", 64'(n_xfer - x0), 64'd4);
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef SCANNER_STALL_COUNT_EN
        chk("bp_stall", 64'(stall_at_done), 64'd3);
`endif

        // Start and limit changes while busy are ignored
        d0 = n_done;
        x0 = n_xfer;
        launch(1'b0, 2, 3);
        repeat (3) step();
        start = 1'b1;
        i_last = IS'(7);
        j_last = JS'(200);
        col_major = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done_seen", 100, d0);
        repeat (6) step();
        chk("ign_xfers", 64'(n_xfer - x0), 64'd12);
        chk("ign_done_cnt", 64'(n_done - d0), 64'd1);
        chk("ign_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-scan after two transfers
        d0 = n_done;
        x0 = n_xfer;
        launch(1'b0, 3, 3);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 64'({busy, done, req_valid, req_bank, req_addr, req_i, req_j}), 64'd0);
        chk("rst_xfers", 64'(n_xfer - x0), 64'd2);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_no_done", 64'(n_done - d0), 64'd0);
        run_scan("single", 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
